elevator_move_timer: RTL and testbench
======================================

# elevator_move_timer

Parametrised movement-timing generator for the elevator controller. Produces the travel clock (`move_clk`) and a one-cycle step strobe that the floor-position logic consumes, gated by the request/handler inputs and frozen by SOS or overweight conditions. Extends the plain move divider with N request lines, a start-up delay before the first step, a true pause state that resumes where it stopped, a step counter and status outputs.

## Interface

Parameters:
- `NUM_REQ`, 3, number of floor request lines (≥1)
- `MOVE_TIME`, 10, terminal count per half-period of `move_clk` (≥1); toggle every MOVE_TIME+1 cycles
- `START_DELAY`, 20, cycles spent in START before stepping begins (0 = skip START)
- `CNT_W`, 26, width of internal counter; MOVE_TIME and START_DELAY must be < 2^CNT_W
- `STEP_W`, 8, width of `step_count`

Ports:
- `clk` in 1 system clock, all logic on rising edge
- `rst` in 1 synchronous, active-high reset
- `req` in NUM_REQ floor request lines (LED state)
- `move_handler` in 1 motion permitted by the floor controller
- `sos_mode` in 1 emergency hold
- `weight_limit_exceeded` in 1 overweight hold
- `move_clk` out 1 travel clock, registered
- `move_tick` out 1 one-cycle strobe per `move_clk` toggle
- `step_count` out STEP_W toggles since last clear, wraps
- `busy` out 1 state ≠ IDLE
- `paused` out 1 state = HOLD

## Operation

- Conditions: clear = `~move_handler & |req`; hold = `sos_mode | weight_limit_exceeded`; go = ~clear & ~hold.
- Priority each edge: `rst` > clear > hold > counting.
- `rst` or clear: state IDLE, counter 0, `move_clk` 0, `move_tick` 0, `step_count` 0, saved state IDLE.
- States:
  - IDLE: on go → START (counter 0) if START_DELAY>0, else → RUN (counter 0). Hold in IDLE: stay IDLE.
  - START: counter increments; when counter = START_DELAY−1 → RUN, counter 0. Hold → HOLD, saved = START.
  - RUN: counter < MOVE_TIME → counter+1; counter = MOVE_TIME → counter 0, `move_clk` inverts, `move_tick` 1, `step_count`+1. Hold → HOLD, saved = RUN.
  - HOLD: counter, `move_clk`, `step_count` frozen; when hold deasserts (and no clear) → saved state, counting resumes from frozen value on following edge.
- Hold sampled in START/RUN suppresses that edge's count/toggle entirely.
- `move_tick` high only in cycle after a toggle edge; never two consecutive cycles (MOVE_TIME ≥1).
- `step_count` modulo 2^STEP_W; 2^STEP_W−1 → 0 with no flag.
- `busy`, `paused` decoded combinationally from registered state.

## Timing

- Reset values: `move_clk`=0, `move_tick`=0, `step_count`=0, `busy`=0, `paused`=0.
- Let edge E0 be the edge at which IDLE samples go. First `move_clk` toggle (0→1) and first `move_tick` at edge E0+START_DELAY+MOVE_TIME+1; thereafter toggle every MOVE_TIME+1 edges (full period 2·(MOVE_TIME+1)).
- `busy` rises after E0; `paused` rises after the first edge sampling hold in START/RUN, falls after first edge sampling hold low.
- A hold of H cycles in START/RUN delays all subsequent toggles by exactly H cycles.
- Clear takes effect at the next edge from any state, including HOLD and mid-START; clear with simultaneous hold → IDLE.
- Reset mid-HOLD → IDLE; saved state discarded.
- No combinational path from inputs to `move_clk`/`move_tick`/`step_count`.

## Test plan

- Reset: assert `rst` 2 cycles with all inputs active → all outputs 0, `busy`=0 after release while inputs idle-clear.
- MOVE_TIME=3, START_DELAY=2, `move_handler`=1, `req`=0: first toggle at E0+6, then every 4 cycles; `move_tick` one cycle each; `step_count` 1,2,3…
- Same config, raise `sos_mode` for 5 cycles when RUN counter=1 → `paused`=1, `move_clk` frozen, next toggle 5 cycles later than nominal; repeat with `weight_limit_exceeded` during START.
- While `move_clk`=1, drive `move_handler`=0, `req`=3'b010 (with `sos_mode`=1 simultaneously) → next edge `move_clk`=0, `step_count`=0, `busy`=0; restart incurs full START_DELAY again.
- STEP_W=8: run 256 toggles → `step_count` 255→0 with toggle timing unaffected.
- START_DELAY=0: first toggle at E0+MOVE_TIME+1; assert `rst` during HOLD → IDLE, no resume when hold drops until go re-sampled.

Source files
------------

// File: rtl/elevator_move_timer.sv
// Movement-timing generator: start-up delay, travel clock divider with step strobe,
// resumable hold on SOS/overweight, and a wrapping step counter.
module elevator_move_timer #(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned MOVE_TIME   = 10,
    parameter int unsigned START_DELAY = 20,
    parameter int unsigned CNT_W       = 26,
    parameter int unsigned STEP_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               move_handler,
    input  logic               sos_mode,
    input  logic               weight_limit_exceeded,
    output logic               move_clk,
    output logic               move_tick,
    output logic [STEP_W-1:0]  step_count,
    output logic               busy,
    output logic               paused
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_HOLD
    } state_t;

    localparam logic [CNT_W-1:0] SD_LAST = CNT_W'(START_DELAY - 1);
    localparam logic [CNT_W-1:0] MT_LAST = CNT_W'(MOVE_TIME);

    state_t             state, state_n;
    state_t             saved, saved_n;
    state_t             phase;
    logic               stepping;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               clk_n;
    logic               tick_n;
    logic [STEP_W-1:0]  step_n;
    logic               clear;
    logic               hold;

    assign clear  = ~move_handler & (|req);
    assign hold   = sos_mode | weight_limit_exceeded;
    assign busy   = (state != S_IDLE);
    assign paused = (state == S_HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            saved      <= S_IDLE;
            cnt        <= '0;
            move_clk   <= 1'b0;
            move_tick  <= 1'b0;
            step_count <= '0;
        end else begin
            state      <= state_n;
            saved      <= saved_n;
            cnt        <= cnt_n;
            move_clk   <= clk_n;
            move_tick  <= tick_n;
            step_count <= step_n;
        end
    end

    always_comb begin
        state_n  = state;
        saved_n  = saved;
        cnt_n    = cnt;
        clk_n    = move_clk;
        tick_n   = 1'b0;
        step_n   = step_count;
        phase    = S_IDLE;
        stepping = 1'b0;

        if (clear) begin
            state_n = S_IDLE;
            saved_n = S_IDLE;
            cnt_n   = '0;
            clk_n   = 1'b0;
            step_n  = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!hold) begin
                        cnt_n   = '0;
                        state_n = (START_DELAY > 0) ? S_START : S_RUN;
                    end
                end
                S_START, S_RUN: begin
                    if (hold) begin
                        state_n = S_HOLD;
                        saved_n = state;
                    end else begin
                        stepping = 1'b1;
                        phase    = state;
                    end
                end
                S_HOLD: begin
                    // The release edge already counts, so an H-cycle hold shifts timing by exactly H.
                    if (!hold) begin
                        state_n  = saved;
                        stepping = 1'b1;
                        phase    = saved;
                    end
                end
                default: state_n = S_IDLE;
            endcase

            if (stepping) begin
                if (phase == S_START) begin
                    if (cnt == SD_LAST) begin
                        state_n = S_RUN;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end else if (phase == S_RUN) begin
                    if (cnt == MT_LAST) begin
                        cnt_n  = '0;
                        clk_n  = ~move_clk;
                        tick_n = 1'b1;
                        step_n = step_count + STEP_W'(1);
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_elevator_move_timer.sv
// Directed bench: two instances (START_DELAY=2 and START_DELAY=0, MOVE_TIME=3) share stimulus;
// observations are taken 1 time unit after each rising edge.
module tb_elevator_move_timer;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic       move_handler;
    logic       sos_mode;
    logic       weight_limit_exceeded;

    logic       clk_a, tick_a, busy_a, paused_a;
    logic [7:0] steps_a;
    logic       clk_b, tick_b, busy_b, paused_b;
    logic [7:0] steps_b;

    int errors = 0;
    int checks = 0;

    elevator_move_timer #(
        .NUM_REQ(3), .MOVE_TIME(3), .START_DELAY(2), .CNT_W(26), .STEP_W(8)
    ) dut_a (
        .clk(clk), .rst(rst), .req(req), .move_handler(move_handler),
        .sos_mode(sos_mode), .weight_limit_exceeded(weight_limit_exceeded),
        .move_clk(clk_a), .move_tick(tick_a), .step_count(steps_a),
        .busy(busy_a), .paused(paused_a)
    );

    elevator_move_timer #(
        .NUM_REQ(3), .MOVE_TIME(3), .START_DELAY(0), .CNT_W(26), .STEP_W(8)
    ) dut_b (
        .clk(clk), .rst(rst), .req(req), .move_handler(move_handler),
        .sos_mode(sos_mode), .weight_limit_exceeded(weight_limit_exceeded),
        .move_clk(clk_b), .move_tick(tick_b), .step_count(steps_b),
        .busy(busy_b), .paused(paused_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with every input active
        rst = 1'b1; req = 3'b111; move_handler = 1'b1;
        sos_mode = 1'b1; weight_limit_exceeded = 1'b1;
        cyc(2);
        check("rst_clk_a",    clk_a,    0);
        check("rst_tick_a",   tick_a,   0);
        check("rst_steps_a",  steps_a,  0);
        check("rst_busy_a",   busy_a,   0);
        check("rst_paused_a", paused_a, 0);
        check("rst_clk_b",    clk_b,    0);
        check("rst_busy_b",   busy_b,   0);

        rst = 1'b0; move_handler = 1'b0; req = 3'b001;
        sos_mode = 1'b0; weight_limit_exceeded = 1'b0;
        cyc(1);
        check("idle_busy_a",   busy_a,   0);
        check("idle_paused_a", paused_a, 0);

        // Go: E0 is the next edge
        move_handler = 1'b1; req = 3'b000;
        cyc(1);
        check("e0_busy_a", busy_a, 1);
        check("e0_clk_a",  clk_a,  0);
        check("e0_busy_b", busy_b, 1);
        cyc(3);
        check("e3_clk_b", clk_b, 0);
        cyc(1);
        check("e4_clk_b",   clk_b,   1);
        check("e4_tick_b",  tick_b,  1);
        check("e4_steps_b", steps_b, 1);
        cyc(1);
        check("e5_clk_a",  clk_a,  0);
        check("e5_tick_a", tick_a, 0);
        check("e5_tick_b", tick_b, 0);
        cyc(1);
        check("e6_clk_a",   clk_a,   1);
        check("e6_tick_a",  tick_a,  1);
        check("e6_steps_a", steps_a, 1);
        cyc(1);
        check("e7_tick_a", tick_a, 0);
        check("e7_clk_a",  clk_a,  1);
        cyc(3);
        check("e10_clk_a",   clk_a,   0);
        check("e10_tick_a",  tick_a,  1);
        check("e10_steps_a", steps_a, 2);
        cyc(1);

        // SOS for 5 cycles with RUN counter at 1: toggle moves from E0+14 to E0+19
        sos_mode = 1'b1;
        cyc(1);
        check("sos_paused_a", paused_a, 1);
        check("sos_busy_a",   busy_a,   1);
        cyc(2);
        check("sos_e14_clk_a",  clk_a,  0);
        check("sos_e14_tick_a", tick_a, 0);
        cyc(2);
        check("sos_e16_paused_a", paused_a, 1);
        sos_mode = 1'b0;
        cyc(1);
        check("sos_e17_paused_a", paused_a, 0);
        cyc(1);
        check("sos_e18_clk_a", clk_a, 0);
        cyc(1);
        check("sos_e19_clk_a",   clk_a,   1);
        check("sos_e19_tick_a",  tick_a,  1);
        check("sos_e19_steps_a", steps_a, 3);

        // Clear with simultaneous SOS while move_clk is high
        move_handler = 1'b0; req = 3'b010; sos_mode = 1'b1;
        cyc(1);
        check("clr_clk_a",    clk_a,    0);
        check("clr_steps_a",  steps_a,  0);
        check("clr_busy_a",   busy_a,   0);
        check("clr_paused_a", paused_a, 0);
        check("clr_tick_a",   tick_a,   0);
        check("clr_busy_b",   busy_b,   0);

        // Restart (F0), overweight for 3 cycles during START: toggle at F0+9
        move_handler = 1'b1; req = 3'b000; sos_mode = 1'b0;
        cyc(1);
        check("f0_busy_a", busy_a, 1);
        weight_limit_exceeded = 1'b1;
        cyc(1);
        check("wl_paused_a", paused_a, 1);
        cyc(2);
        check("wl_f3_paused_a", paused_a, 1);
        weight_limit_exceeded = 1'b0;
        cyc(1);
        check("wl_f4_paused_a", paused_a, 0);
        cyc(4);
        check("wl_f8_clk_a", clk_a, 0);
        cyc(1);
        check("wl_f9_clk_a",   clk_a,   1);
        check("wl_f9_tick_a",  tick_a,  1);
        check("wl_f9_steps_a", steps_a, 1);

        // Step counter wrap 255 -> 0
        cyc(4 * 254);
        check("wrap_255_steps_a", steps_a, 255);
        check("wrap_255_tick_a",  tick_a,  1);
        check("wrap_255_clk_a",   clk_a,   1);
        cyc(3);
        check("wrap_pre_tick_a", tick_a, 0);
        check("wrap_pre_clk_a",  clk_a,  1);
        cyc(1);
        check("wrap_0_steps_a", steps_a, 0);
        check("wrap_0_tick_a",  tick_a,  1);
        check("wrap_0_clk_a",   clk_a,   0);

        // START_DELAY=0 instance: first toggle at G0+4, then reset during HOLD
        move_handler = 1'b0; req = 3'b001;
        cyc(1);
        check("b_clr_busy", busy_b, 0);
        move_handler = 1'b1; req = 3'b000;
        cyc(1);
        check("b_g0_busy", busy_b, 1);
        cyc(3);
        check("b_g3_clk", clk_b, 0);
        cyc(1);
        check("b_g4_clk",   clk_b,   1);
        check("b_g4_tick",  tick_b,  1);
        check("b_g4_steps", steps_b, 1);
        sos_mode = 1'b1;
        cyc(1);
        check("b_hold_paused", paused_b, 1);
        rst = 1'b1;
        cyc(1);
        check("b_rst_busy",   busy_b,   0);
        check("b_rst_paused", paused_b, 0);
        check("b_rst_clk",    clk_b,    0);
        check("b_rst_steps",  steps_b,  0);
        rst = 1'b0;
        cyc(2);
        check("b_noresume_busy",   busy_b,   0);
        check("b_noresume_paused", paused_b, 0);
        sos_mode = 1'b0;
        cyc(1);
        check("b_h0_busy", busy_b, 1);
        check("b_h0_clk",  clk_b,  0);
        cyc(3);
        check("b_h3_clk", clk_b, 0);
        cyc(1);
        check("b_h4_clk",   clk_b,   1);
        check("b_h4_steps", steps_b, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
